// File: rtl/pipe_exe_md.sv
// Execute stage: ALU/shift/jal datapath plus an iterative multiply/divide
// unit with HI/LO registers that stalls the pipeline while it works.
//
// Handshake: estall is the only flow control. While estall=1 the pipeline
// holds the EXE instruction and inserts a bubble into MEM. An instruction
// in EXE retires on any edge where ev=1 and estall=0.
module pipe_exe_md #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            ev,
    input  logic            eflush,
    input  logic [3:0]      ealuc,
    input  logic            ealuimm,
    input  logic            eshift,
    input  logic            ejal,
    input  logic [3:0]      emdop,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [XLEN-1:0] eimm,
    input  logic [XLEN-1:0] epc4,
    input  logic [4:0]      ern0,
    output logic [XLEN-1:0] ealu,
    output logic [4:0]      ern,
    output logic            estall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [SW-1:0]   cnt;
    logic [XLEN-1:0] alu_a, alu_b, alu_r;
    logic [SW-1:0]   shamt;

    // ALU operand selection and operation decode
    always_comb begin
        alu_a = eshift ? {{(XLEN-5){1'b0}}, eimm[10:6]} : ea;
        alu_b = ealuimm ? eimm : eb;
        shamt = alu_a[SW-1:0];
        alu_r = '0;
        case (ealuc[1:0])
            2'b00: alu_r = ealuc[2] ? (alu_a - alu_b) : (alu_a + alu_b);
            2'b01: alu_r = ealuc[2] ? (alu_a | alu_b) : (alu_a & alu_b);
            2'b10: alu_r = ealuc[2] ? (alu_b << 16) : (alu_a ^ alu_b);
            default: begin
                if (!ealuc[2])     alu_r = alu_b << shamt;
                else if (ealuc[3]) alu_r = XLEN'($signed(alu_b) >>> shamt);
                else               alu_r = alu_b >> shamt;
            end
        endcase
    end

    // Result and destination selection toward MEM
    always_comb begin
        if (ejal)                ealu = epc4 + XLEN'(4);
        else if (emdop == 4'd5)  ealu = hi;
        else if (emdop == 4'd6)  ealu = lo;
        else                     ealu = alu_r;
        if (ejal)
            ern = 5'b11111;
        else if ((emdop >= 4'd1 && emdop <= 4'd4) || emdop == 4'd7 || emdop == 4'd8)
            ern = 5'd0;
        else
            ern = ern0;
    end

    // Operation decode and operand magnitudes for the md unit
    logic            md_op, op_signed, op_div, start;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    assign md_op     = (emdop >= 4'd1) && (emdop <= 4'd4);
    assign op_signed = (emdop == 4'd1) || (emdop == 4'd3);
    assign op_div    = (emdop == 4'd3) || (emdop == 4'd4);
    assign start     = ev && !eflush && md_op && (state == IDLE);
    assign a_neg     = op_signed && ea[XLEN-1];
    assign b_neg     = op_signed && eb[XLEN-1];
    assign a_abs     = a_neg ? -ea : ea;
    assign b_abs     = b_neg ? -eb : eb;

    // Iteration registers: acc = partial product high / remainder,
    // qr = multiplier / dividend shifting into quotient, bm = |b|
    logic [XLEN-1:0] acc, qr, bm;
    logic            neg_q, neg_r, is_div, b_zero;

    logic [XLEN:0]     m_sum, d_rs, d_diff;
    logic [XLEN-1:0]   acc_n, q_n, res_hi, res_lo;
    logic [2*XLEN-1:0] prod, prod_s, fast, fast_s;

    // One shift-add or restoring-divide step, plus sign correction
    always_comb begin
        m_sum  = {1'b0, acc} + (qr[0] ? {1'b0, bm} : '0);
        d_rs   = {acc, qr[XLEN-1]};
        d_diff = d_rs - {1'b0, bm};
        if (is_div) begin
            if (!d_diff[XLEN]) begin
                acc_n = d_diff[XLEN-1:0];
                q_n   = {qr[XLEN-2:0], 1'b1};
            end else begin
                acc_n = d_rs[XLEN-1:0];
                q_n   = {qr[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_n = m_sum[XLEN:1];
            q_n   = {m_sum[0], qr[XLEN-1:1]};
        end
        prod   = {acc_n, q_n};
        prod_s = neg_q ? -prod : prod;
        if (is_div) begin
            res_hi = neg_r ? -acc_n : acc_n;
            res_lo = b_zero ? '1 : (neg_q ? -q_n : q_n);
        end else begin
            res_hi = prod_s[2*XLEN-1:XLEN];
            res_lo = prod_s[XLEN-1:0];
        end
        fast   = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
        fast_s = (a_neg ^ b_neg) ? -fast : fast;
    end

    // Next-state and stall logic
    always_comb begin
        state_nx = state;
        estall   = 1'b0;
        case (state)
            IDLE: begin
                estall = start;
                if (start) state_nx = ((FAST_MUL != 0) && !op_div) ? DONE : BUSY;
            end
            BUSY: begin
                estall = 1'b1;
                if (eflush)        state_nx = IDLE;
                else if (cnt == 0) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Iteration datapath: load on start, step while busy
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0; acc <= '0; qr <= '0; bm <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; is_div <= 1'b0; b_zero <= 1'b0;
        end else if (start) begin
            cnt    <= SW'(XLEN-1);
            acc    <= '0;
            qr     <= a_abs;
            bm     <= b_abs;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            is_div <= op_div;
            b_zero <= (eb == '0);
        end else if (state == BUSY) begin
            if (eflush) begin
                cnt <= '0;
            end else begin
                acc <= acc_n;
                qr  <= q_n;
                if (cnt != 0) cnt <= cnt - 1'b1;
            end
        end
    end

    // HI/LO: md result, single-cycle product, or mthi/mtlo
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state == BUSY && !eflush && cnt == 0) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if ((FAST_MUL != 0) && start && !op_div) begin
            hi <= fast_s[2*XLEN-1:XLEN];
            lo <= fast_s[XLEN-1:0];
        end else if (ev && !eflush && !estall) begin
            if (emdop == 4'd7) hi <= ea;
            if (emdop == 4'd8) lo <= ea;
        end
    end
endmodule
